// File: rtl/clk_ctrl_pkg.sv
// rtl/clk_ctrl_pkg.sv - shared state encoding and error codes for the clock switch sequencer
package clk_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SETTLE = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } sw_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DEAD = 2'b01;  // target not alive when checked
    localparam logic [1:0] ERR_LOST = 2'b10;  // target dropped while settling

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer with sync active-low reset to 0
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back flops; only q is safe to use in the clk domain.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_sw_ctrl.sv
// rtl/clk_sw_ctrl.sv - sequences the glitch-free clock mux select with liveness check and settle window
module clk_sw_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 8,
    parameter bit RST_SEL    = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_req,
    input  logic       i_tgt,
    input  logic       i_clk0_alive,
    input  logic       i_clk1_alive,
    output logic       o_sel,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [1:0] o_err_code
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    sw_state_t        state;
    logic             tgt_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       alive_s;

    sync_2ff #(.W(1)) u_sync_clk0 (
        .clk  (i_clk),
        .rstn (i_rstn),
        .d    (i_clk0_alive),
        .q    (alive_s[0])
    );

    sync_2ff #(.W(1)) u_sync_clk1 (
        .clk  (i_clk),
        .rstn (i_rstn),
        .d    (i_clk1_alive),
        .q    (alive_s[1])
    );

    // Switch FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state      <= IDLE;
            tgt_q      <= 1'b0;
            cnt        <= '0;
            o_sel      <= RST_SEL;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= ERR_NONE;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        tgt_q  <= i_tgt;
                        state  <= CHECK;
                        o_busy <= 1'b1;
                    end
                end
                CHECK: begin
                    if (tgt_q == o_sel) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else if (!alive_s[tgt_q]) begin
                        state      <= ERR;
                        o_err      <= 1'b1;
                        o_err_code <= ERR_DEAD;
                    end else begin
                        o_sel <= tgt_q;
                        cnt   <= SETTLE_LOAD;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Loss of the new clock takes priority over completion; o_sel is left
                    // on the target so recovery is a software decision.
                    if (!alive_s[tgt_q]) begin
                        state      <= ERR;
                        o_err      <= 1'b1;
                        o_err_code <= ERR_LOST;
                    end else if (cnt == '0) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE, ERR: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_sw_ctrl.sv
// tb/tb_clk_sw_ctrl.sv - scoreboard testbench for clk_sw_ctrl
module tb_clk_sw_ctrl;

    logic       clk;
    logic       rstn;
    logic       req;
    logic       tgt;
    logic       alive0;
    logic       alive1;
    logic       sel;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        logic       sel;
        int         cyc;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    clk_sw_ctrl #(
        .SETTLE_CYC (16),
        .CNT_W      (8),
        .RST_SEL    (1'b0)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_req        (req),
        .i_tgt        (tgt),
        .i_clk0_alive (alive0),
        .i_clk1_alive (alive1),
        .o_sel        (sel),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT emits a done or err pulse.
    always @(negedge clk) begin
        if (rstn) begin
            if (done && err) chk("done_err_overlap", 1, 0);
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_kind"}, int'(err), int'(e.is_err));
                    if (e.is_err) chk({e.name, "_code"}, int'(err_code), int'(e.code));
                    chk({e.name, "_sel"}, int'(sel), int'(e.sel));
                    chk({e.name, "_cycle"}, cyc, e.cyc);
                end
            end
        end
    end

    task automatic expect_pulse(input string name, input bit is_err, input logic [1:0] code,
                                input logic s, input int at);
        exp_t e;
        e.name = name; e.is_err = is_err; e.code = code; e.sel = s; e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Issues a one-cycle request; returns acceptance cycle and leaves us at cycle a+1.
    task automatic request(input logic t, output int a);
        req = 1'b1;
        tgt = t;
        a   = cyc;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("busy_timeout", 1, 0);
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    int a;
    int n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; req = 1'b0; tgt = 1'b0; alive0 = 1'b1; alive1 = 1'b1;
        idle_cycles(3);
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_code", int'(err_code), 0);
        rstn = 1'b1;
        idle_cycles(3);

        // Normal switch 0 -> 1
        expect_pulse("sw01", 1'b0, 2'b00, 1'b1, cyc + 18);
        request(1'b1, a);
        chk("sw01_busy_c1", int'(busy), 1);
        chk("sw01_sel_c1", int'(sel), 0);
        @(negedge clk);
        chk("sw01_sel_c2", int'(sel), 1);
        wait_idle(n);
        chk("sw01_busy_len", n, 17);
        idle_cycles(2);

        // Same target: immediate done
        expect_pulse("same1", 1'b0, 2'b00, 1'b1, cyc + 2);
        request(1'b1, a);
        wait_idle(n);
        chk("same1_busy_len", n, 2);
        chk("same1_sel", int'(sel), 1);
        idle_cycles(2);

        // Back to clk0, then request dead clk1
        expect_pulse("sw10", 1'b0, 2'b00, 1'b0, cyc + 18);
        request(1'b0, a);
        wait_idle(n);
        chk("sw10_busy_len", n, 18);
        alive1 = 1'b0;
        idle_cycles(3);
        expect_pulse("dead1", 1'b1, 2'b01, 1'b0, cyc + 2);
        request(1'b1, a);
        wait_idle(n);
        chk("dead1_busy_len", n, 2);
        chk("dead1_sel", int'(sel), 0);
        alive1 = 1'b1;
        idle_cycles(3);

        // Target lost during settle
        expect_pulse("lost1", 1'b1, 2'b10, 1'b1, cyc + 9);
        request(1'b1, a);
        idle_cycles(5);
        alive1 = 1'b0;
        wait_idle(n);
        chk("lost1_busy_len", n, 4);
        chk("lost1_sel", int'(sel), 1);
        alive1 = 1'b1;
        idle_cycles(3);

        // Second request mid-switch with flipped target is ignored
        expect_pulse("ign", 1'b0, 2'b00, 1'b0, cyc + 18);
        request(1'b0, a);
        idle_cycles(4);
        req = 1'b1; tgt = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_idle(n);
        chk("ign_busy_len", n, 13);
        chk("ign_sel", int'(sel), 0);
        idle_cycles(3);
        chk("ign_no_retrigger", int'(busy), 0);

        // Reset in the middle of SETTLE aborts without a pulse
        request(1'b1, a);
        idle_cycles(7);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_sel", int'(sel), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(err), 0);
        rstn = 1'b1;
        idle_cycles(3);
        expect_pulse("post_rst", 1'b0, 2'b00, 1'b1, cyc + 18);
        request(1'b1, a);
        wait_idle(n);
        chk("post_rst_busy_len", n, 18);
        idle_cycles(3);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_sw_ctrl.md
Name: clk_sw_ctrl

Overview:
- Switch sequencer that drives the select input of the glitch-free two-clock mux (clk_mux) from an always-on control clock.
- Accepts a switch request, checks the target clock is alive, then drives the select.
- Holds off for a fixed settle window that covers the mux's two-flop enable handover, then reports completion or error.
- Sits in the clock/reset controller, one instance per clock_mux.

Parameters:
- SETTLE_CYC, 16: i_clk cycles o_sel is held before o_done. Must cover 2 edges of the slower muxed clock plus 2 of the other, in i_clk time. Legal range 1..255.
- CNT_W, 8: settle counter width. Must satisfy 2^CNT_W > SETTLE_CYC.
- RST_SEL, 0: o_sel value after reset.

Ports:
- i_clk  input  1  control clock, always running
- i_rstn  input  1  reset, synchronous, active-low
- i_req  input  1  switch request, level; sampled only in IDLE
- i_tgt  input  1  requested select: 0 = clk0, 1 = clk1
- i_clk0_alive  input  1  clk0 present flag, asynchronous to i_clk
- i_clk1_alive  input  1  clk1 present flag, asynchronous to i_clk
- o_sel  output  1  registered select to clk_mux i_sel
- o_busy  output  1  high from the cycle after acceptance until return to IDLE
- o_done  output  1  one-cycle pulse, switch complete
- o_err  output  1  one-cycle pulse, switch failed
- o_err_code  output  2  valid with o_err: 01 = target dead at check, 10 = target lost during settle; holds its last value otherwise

Behaviour:
- Reset (i_rstn=0 at a posedge i_clk):
  - state=IDLE, o_sel=RST_SEL.
  - o_busy, o_done, o_err = 0; o_err_code = 00; counter = 0; synchronizer flops = 0.
  - Reset mid-operation aborts immediately to these values; no pulse is emitted.
- Alive inputs pass through a 2-flop synchronizer. alive_s[n] lags the raw input by 2 cycles, and all decisions use alive_s.
- FSM states: IDLE, CHECK, SETTLE, DONE, ERR. All outputs are registered.
- IDLE:
  - If i_req=1: latch tgt_q=i_tgt, go to CHECK, o_busy=1 from the next cycle.
  - If i_req=0: stay in IDLE.
- CHECK (one cycle):
  - If tgt_q==o_sel: go to DONE with no settle.
  - Else if alive_s[tgt_q]==0: go to ERR with code 01; o_sel unchanged.
  - Else: o_sel<=tgt_q, counter<=SETTLE_CYC-1, go to SETTLE.
- SETTLE:
  - If alive_s[tgt_q]==0: go to ERR with code 10. o_sel stays at tgt_q; there is no revert, and software decides recovery.
  - Else if counter==0: go to DONE.
  - Else: counter decrements.
  - If the loss coincides with counter==0, the error wins.
- DONE (one cycle): o_done=1, then IDLE.
- ERR (one cycle): o_err=1 and o_err_code set, then IDLE.
- o_busy: 1 in CHECK, SETTLE, DONE and ERR; 0 in IDLE.
- Timing, with acceptance at cycle 0:
  - o_sel changes at cycle 2.
  - o_done is high at cycle 2+SETTLE_CYC.
  - A same-target request gives o_done at cycle 2.
  - A dead target gives o_err at cycle 2.
- i_req and i_tgt are ignored while o_busy=1. There is no queue, so the requester must re-request.
- A request held high re-triggers on the first IDLE cycle after completion. Requesters drop i_req on o_done or o_err.
- o_done and o_err are never high together. The counter never wraps: it is loaded only in CHECK and stops at 0.

Decomposition:
- Shared package clk_ctrl_pkg: state encoding constants (IDLE=0, CHECK=1, SETTLE=2, DONE=3, ERR=4), error codes (ERR_DEAD=2'b01, ERR_LOST=2'b10).
- One sub-module, sync_2ff: generic 2-flop synchronizer, instantiated for each alive input, sync active-low reset to 0.

Test Plan:
- Reset release, then i_req=1, i_tgt=1, both alive=1 (settled ≥2 cycles), SETTLE_CYC=16 → o_sel 0→1 at cycle 2; o_done pulse at cycle 18; o_busy=1 for cycles 1..18; o_err never high.
- o_sel=1, request i_tgt=1 → o_done at cycle 2; o_sel stays 1; counter not loaded.
- i_clk1_alive=0, request i_tgt=1 from o_sel=0 → o_err at cycle 2 with o_err_code=01; o_sel stays 0.
- Valid switch to clk1; drop i_clk1_alive at cycle 6 → alive_s falls at cycle 8; o_err with code 10 at cycle 9; o_sel stays 1; no o_done.
- Second i_req pulse at cycle 5 of a switch with i_tgt flipped → ignored; single o_done at cycle 18 for the original target.
- Assert i_rstn=0 at cycle 7 of SETTLE → next cycle o_sel=RST_SEL and o_busy=0; no o_done or o_err pulse. A fresh request after release completes normally.
